// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetromino renderer: shape codes,
// the committed-cell record, the build state machine encoding and the shape ROM.
package tetris_pkg;

   localparam logic [2:0] PIECE_I    = 3'd0;
   localparam logic [2:0] PIECE_O    = 3'd1;
   localparam logic [2:0] PIECE_T    = 3'd2;
   localparam logic [2:0] PIECE_S    = 3'd3;
   localparam logic [2:0] PIECE_Z    = 3'd4;
   localparam logic [2:0] PIECE_J    = 3'd5;
   localparam logic [2:0] PIECE_L    = 3'd6;
   localparam logic [2:0] PIECE_NONE = 3'd7;

   // Stored coordinate width; the renderer's CW must not exceed it.
   localparam int COORD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               valid;
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUILD  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Each entry is {c[1:0], r[1:0]} within the 4x4 bounding grid, rotation 0.
   localparam logic [3:0] SHAPE_ROM [0:6][0:3] = '{
      '{4'h0, 4'h4, 4'h8, 4'hC},   // I
      '{4'h4, 4'h8, 4'h5, 4'h9},   // O
      '{4'h1, 4'h5, 4'h9, 4'h6},   // T
      '{4'h4, 4'h8, 4'h1, 4'h5},   // S
      '{4'h0, 4'h4, 4'h5, 4'h9},   // Z
      '{4'h0, 4'h1, 4'h5, 4'h9},   // J
      '{4'h8, 4'h1, 4'h5, 4'h9}    // L
   };

endpackage

// File: rtl/tetromino_shape_rom.sv
// Combinational base-shape lookup: (piece, cell index) -> grid cell (c,r).
// The "none" code returns cell (0,0); the caller marks such cells invalid.
module tetromino_shape_rom
   import tetris_pkg::*;
(
   input  logic [2:0] piece_i,
   input  logic [1:0] idx_i,
   output logic [1:0] col_o,
   output logic [1:0] row_o
);

   always_comb begin
      {col_o, row_o} = 4'h0;
      if (piece_i != PIECE_NONE) begin
         {col_o, row_o} = SHAPE_ROM[piece_i][idx_i];
      end
   end

endmodule

// File: rtl/tetromino_render.sv
// Tetromino renderer: a load-time FSM builds four cell origins into a shadow
// set and commits them atomically; a 2-stage hit test drives en_inner/en_edge.
module tetromino_render
   import tetris_pkg::*;
#(
   parameter int SIZE = 16,
   parameter int EDGE = 1,
   parameter int CW   = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [2:0]    piece,
   input  logic [1:0]    rot,
   input  logic [CW-1:0] ref_x,
   input  logic [CW-1:0] ref_y,
   output logic          busy,
   output logic          done,
   input  logic [CW-1:0] addr_x,
   input  logic [CW-1:0] addr_y,
   output logic          en_inner,
   output logic          en_edge,
   output logic [1:0]    dbg_state_o
);

   localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(SIZE);
   localparam logic [COORD_W-1:0] EDGE_C = COORD_W'(EDGE);
   localparam logic [COORD_W-1:0] HI_C   = COORD_W'(SIZE - EDGE);

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic          latch_en;
   logic [2:0]    piece_q;
   logic [1:0]    rot_q;
   logic [CW-1:0] ref_x_q, ref_y_q;
   cell_t         shadow_q [4];
   cell_t         active_q [4];

   logic [1:0]    rom_c, rom_r, c_rot, r_rot;
   logic [CW:0]   x_sum, y_sum;
   cell_t         build_cell;

   logic [COORD_W-1:0] ax, ay;
   logic [COORD_W-1:0] hit_dx [4];
   logic [COORD_W-1:0] hit_dy [4];
   logic [3:0]    inside_d, band_d, inner_d, edge_d;
   logic [3:0]    inner_s1_q, edge_s1_q;
   logic          en_inner_q, en_edge_q;

   // ---------------- load-time state machine ----------------
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      latch_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               latch_en = 1'b1;
               idx_d    = 2'd0;
               state_d  = ST_BUILD;
            end
         end
         ST_BUILD: begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign busy        = (state_q == ST_BUILD);
   assign done        = (state_q == ST_COMMIT);
   assign dbg_state_o = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         piece_q <= PIECE_NONE;
         rot_q   <= 2'd0;
         ref_x_q <= '0;
         ref_y_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (latch_en) begin
            piece_q <= piece;
            rot_q   <= rot;
            ref_x_q <= ref_x;
            ref_y_q <= ref_y;
         end
      end
   end

   // ---------------- cell build: ROM, rotate, place ----------------
   tetromino_shape_rom u_rom (
      .piece_i (piece_q),
      .idx_i   (idx_q),
      .col_o   (rom_c),
      .row_o   (rom_r)
   );

   always_comb begin
      c_rot = rom_c;
      r_rot = rom_r;
      case (rot_q)
         2'd1:    begin c_rot = 2'd3 - rom_r; r_rot = rom_c;         end
         2'd2:    begin c_rot = 2'd3 - rom_c; r_rot = 2'd3 - rom_r;  end
         2'd3:    begin c_rot = rom_r;        r_rot = 2'd3 - rom_c;  end
         default: begin c_rot = rom_c;        r_rot = rom_r;         end
      endcase
   end

   // One extra bit so a cell past the screen edge is flagged, never wrapped.
   assign x_sum = (CW+1)'(ref_x_q) + (CW+1)'(c_rot) * (CW+1)'(SIZE);
   assign y_sum = (CW+1)'(ref_y_q) + (CW+1)'(r_rot) * (CW+1)'(SIZE);

   always_comb begin
      build_cell       = '0;
      build_cell.x     = COORD_W'(x_sum[CW-1:0]);
      build_cell.y     = COORD_W'(y_sum[CW-1:0]);
      build_cell.valid = !x_sum[CW] && !y_sum[CW] && (piece_q != PIECE_NONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         if (state_q == ST_BUILD) shadow_q[idx_q] <= build_cell;
         if (state_q == ST_COMMIT) begin
            for (int i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
         end
      end
   end

   // ---------------- two-stage hit test on the active set ----------------
   assign ax = COORD_W'(addr_x);
   assign ay = COORD_W'(addr_y);

   always_comb begin
      inside_d = '0;
      band_d   = '0;
      inner_d  = '0;
      edge_d   = '0;
      for (int i = 0; i < 4; i++) begin
         hit_dx[i]   = ax - active_q[i].x;
         hit_dy[i]   = ay - active_q[i].y;
         inside_d[i] = active_q[i].valid && (ax >= active_q[i].x) && (ay >= active_q[i].y)
                       && (hit_dx[i] < SIZE_C) && (hit_dy[i] < SIZE_C);
         band_d[i]   = (hit_dx[i] < EDGE_C) || (hit_dx[i] >= HI_C)
                       || (hit_dy[i] < EDGE_C) || (hit_dy[i] >= HI_C);
         inner_d[i]  = inside_d[i] && !band_d[i];
         edge_d[i]   = inside_d[i] && band_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inner_s1_q <= '0;
         edge_s1_q  <= '0;
         en_inner_q <= 1'b0;
         en_edge_q  <= 1'b0;
      end else begin
         inner_s1_q <= inner_d;
         edge_s1_q  <= edge_d;
         en_inner_q <= |inner_s1_q;
         en_edge_q  <= |edge_s1_q;
      end
   end

   assign en_inner = en_inner_q;
   assign en_edge  = en_edge_q;

endmodule

// File: tb/tb_tetromino_render.sv
// Directed bench for tetromino_render: load timing, shapes and rotations,
// off-screen cells, ignored loads, reset mid-build and the empty piece.
module tb_tetromino_render;

   localparam int SIZE = 16;
   localparam int EDGE = 1;
   localparam int CW   = 10;

   localparam logic [1:0] NO = 2'b00;
   localparam logic [1:0] IN = 2'b10;
   localparam logic [1:0] ED = 2'b01;

   logic          clk = 1'b0;
   logic          reset, load;
   logic [2:0]    piece;
   logic [1:0]    rot;
   logic [CW-1:0] ref_x, ref_y, addr_x, addr_y;
   logic          busy, done, en_inner, en_edge;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   // Pixel scoreboard: expected {inner, edge} per presented address.
   logic [1:0] exp_q [$];
   int         px_x_q [$];
   int         px_y_q [$];

   // Small reference model of the current piece (pixel origins).
   int mdl_x [4];
   int mdl_y [4];
   bit mdl_v [4];

   tetromino_render #(.SIZE(SIZE), .EDGE(EDGE), .CW(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .piece       (piece),
      .rot         (rot),
      .ref_x       (ref_x),
      .ref_y       (ref_y),
      .busy        (busy),
      .done        (done),
      .addr_x      (addr_x),
      .addr_y      (addr_y),
      .en_inner    (en_inner),
      .en_edge     (en_edge),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_cmp();
      int         x, y;
      logic [1:0] e;
      x = px_x_q.pop_front();
      y = px_y_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("px(%0d,%0d)", x, y), {30'd0, en_inner, en_edge}, {30'd0, e});
   endtask

   // Presents one pixel per cycle; the result emerges two edges later.
   task automatic drive_px(input int x, input int y, input logic [1:0] e);
      addr_x = CW'(x);
      addr_y = CW'(y);
      exp_q.push_back(e);
      px_x_q.push_back(x);
      px_y_q.push_back(y);
      tick();
      if (exp_q.size() == 2) pop_cmp();
   endtask

   task automatic flush_px();
      tick();
      if (exp_q.size() > 0) pop_cmp();
   endtask

   function automatic logic [1:0] model_px(input int x, input int y);
      logic [1:0] r;
      int dx, dy;
      r = NO;
      for (int i = 0; i < 4; i++) begin
         dx = x - mdl_x[i];
         dy = y - mdl_y[i];
         if (mdl_v[i] && dx >= 0 && dx < SIZE && dy >= 0 && dy < SIZE) begin
            if (dx < EDGE || dx >= SIZE - EDGE || dy < EDGE || dy >= SIZE - EDGE) r = ED;
            else r = IN;
         end
      end
      return r;
   endfunction

   // Cell centre and left-edge pixel of every grid cell against a hand mask (bit r*4+c).
   task automatic grid_check(input int rx, input int ry, input logic [15:0] mask);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            drive_px(rx + SIZE*c + 8, ry + SIZE*r + 8, mask[r*4+c] ? IN : NO);
            drive_px(rx + SIZE*c,     ry + SIZE*r + 8, mask[r*4+c] ? ED : NO);
         end
      end
      flush_px();
   endtask

   task automatic blank_sweep(input int ystep);
      for (int y = 0; y < 1024; y += ystep) begin
         for (int x = 0; x < 1024; x += 8) drive_px(x, y, NO);
      end
      flush_px();
   endtask

   task automatic do_load(input logic [2:0] p, input logic [1:0] r, input int rx, input int ry);
      piece = p;
      rot   = r;
      ref_x = CW'(rx);
      ref_y = CW'(ry);
      load  = 1'b1;
      tick();
      load  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("p%0d busy c%0d", p, i + 1), {31'd0, busy}, 32'd1);
         check($sformatf("p%0d done c%0d", p, i + 1), {31'd0, done}, 32'd0);
         tick();
      end
      check($sformatf("p%0d done c5", p), {31'd0, done}, 32'd1);
      check($sformatf("p%0d busy c5", p), {31'd0, busy}, 32'd0);
      tick();
      check($sformatf("p%0d done c6", p), {31'd0, done}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int dcount, bcount;
      reset = 1'b1; load = 1'b0; piece = 3'd0; rot = 2'd0;
      ref_x = '0; ref_y = '0; addr_x = '0; addr_y = '0;
      repeat (3) tick();
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst en_inner", {31'd0, en_inner}, 32'd0);
      check("rst en_edge", {31'd0, en_edge}, 32'd0);
      check("rst state", {30'd0, dbg_state}, 32'd0);
      reset = 1'b0;
      tick();

      // I, rot 0, at (100,50): cells at x = 100, 116, 132, 148
      do_load(3'd0, 2'd0, 100, 50);
      drive_px( 99, 55, NO); drive_px(100, 55, ED); drive_px(101, 55, IN);
      drive_px(114, 55, IN); drive_px(115, 55, ED); drive_px(116, 55, ED);
      drive_px(117, 55, IN); drive_px(131, 55, ED); drive_px(163, 55, ED);
      drive_px(164, 55, NO); drive_px(130, 55, IN); drive_px(108, 50, ED);
      drive_px(108, 65, ED); drive_px(108, 66, NO); drive_px(108, 49, NO);
      for (int i = 0; i < 4; i++) begin
         mdl_x[i] = 100 + SIZE*i; mdl_y[i] = 50; mdl_v[i] = 1'b1;
      end
      for (int x = 96; x <= 168; x++) drive_px(x, 55, model_px(x, 55));
      flush_px();

      // T, rot 1, at (0,0); old I piece must stay visible until commit
      piece = 3'd2; rot = 2'd1; ref_x = '0; ref_y = '0;
      addr_x = CW'(108); addr_y = CW'(58);
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("T busy c%0d", i + 1), {31'd0, busy}, 32'd1);
         drive_px(108, 58, IN);
      end
      check("T done c5", {31'd0, done}, 32'd1);
      drive_px(108, 58, IN);
      drive_px(108, 58, NO);
      drive_px(47, 47, ED); drive_px(15, 24, NO); drive_px(16, 24, ED);
      drive_px(24, 8, NO);  drive_px(32, 0, ED);  drive_px(40, 56, NO);
      flush_px();
      grid_check(0, 0, 16'h0464);

      // Remaining shapes and rotations
      do_load(3'd3, 2'd2, 0, 0);     grid_check(0, 0, 16'h6C00);
      do_load(3'd5, 2'd3, 300, 200); grid_check(300, 200, 16'h3220);
      do_load(3'd1, 2'd0, 0, 0);     grid_check(0, 0, 16'h0066);
      do_load(3'd4, 2'd1, 0, 0);     grid_check(0, 0, 16'h04C8);
      do_load(3'd6, 2'd0, 0, 0);     grid_check(0, 0, 16'h0074);
      do_load(3'd0, 2'd3, 0, 0);     grid_check(0, 0, 16'h1111);

      // I at ref_x 1000: cells at 1032 and 1048 fall off screen
      do_load(3'd0, 2'd0, 1000, 0);
      drive_px(1000, 8, ED); drive_px(1008, 8, IN); drive_px(1015, 8, ED);
      drive_px(1016, 8, ED); drive_px(1020, 8, IN); drive_px(1023, 8, IN);
      drive_px(1008, 16, NO);
      for (int x = 0; x <= 23; x++) drive_px(x, 8, NO);
      flush_px();

      // Vertical I at ref_y 1000: bottom two cells fall off screen
      do_load(3'd0, 2'd3, 0, 1000);
      drive_px(8, 1008, IN); drive_px(8, 1020, IN); drive_px(0, 1010, ED);
      drive_px(8, 8, NO);    drive_px(8, 20, NO);
      flush_px();

      // Loads while busy and in the commit cycle are dropped
      piece = 3'd0; rot = 2'd0; ref_x = CW'(200); ref_y = CW'(100);
      load = 1'b1;
      tick();
      piece = 3'd1; ref_x = '0; ref_y = '0;
      dcount = 0;
      bcount = 0;
      for (int i = 1; i <= 12; i++) begin
         dcount += int'(done);
         bcount += int'(busy);
         load = (i == 1) || (i == 2) || (i == 5);
         tick();
      end
      load = 1'b0;
      check("dup done pulses", 32'(dcount), 32'd1);
      check("dup busy cycles", 32'(bcount), 32'd4);
      drive_px(208, 108, IN); drive_px(200, 108, ED); drive_px(263, 108, ED);
      drive_px(264, 108, NO); drive_px(24, 8, NO);    drive_px(40, 8, NO);
      flush_px();

      // Reset during build cycle with index 2
      piece = 3'd6; rot = 2'd0; ref_x = '0; ref_y = '0;
      addr_x = CW'(208); addr_y = CW'(108);
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      check("mid busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort en_inner", {31'd0, en_inner}, 32'd0);
      check("abort en_edge", {31'd0, en_edge}, 32'd0);
      check("abort state", {30'd0, dbg_state}, 32'd0);
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         dcount += int'(done);
         tick();
      end
      check("abort no done", 32'(dcount), 32'd0);
      drive_px(208, 108, NO);
      drive_px(40, 8, NO);
      blank_sweep(32);

      // Piece 7: commits but never renders
      do_load(3'd7, 2'd0, 0, 0);
      drive_px(8, 8, NO);
      blank_sweep(16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
